// File: rtl/rr_select_arbiter.sv
// Round-robin arbiter driving the select of a downstream 8:1 registered mux.
// A grant is held until ack, until its request drops, or until TIMEOUT cycles elapse.
module rr_select_arbiter #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] req,
   input  logic       ack,
   output logic [2:0] select,
   output logic       grant_valid,
   output logic [7:0] grant_onehot,
   output logic       timeout,
   output logic       fsm_state
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] GRANT = 1'b1;
   localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT - 1);

   logic [0:0] state;
   logic [2:0] ptr;
   logic [7:0] count;
   logic [2:0] pick;
   logic       found;
   logic       rel_ack;
   logic       rel_drop;
   logic       rel_tmo;

   // First requesting channel in search order ptr, ptr+1, ... (mod 8).
   always_comb begin
      pick  = ptr;
      found = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (!found && req[3'(ptr + 3'(i))]) begin
            pick  = 3'(ptr + 3'(i));
            found = 1'b1;
         end
      end
   end

   assign rel_ack  = ack;
   assign rel_drop = !req[select];
   assign rel_tmo  = (count == LAST_COUNT);

   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= IDLE;
         ptr          <= 3'd0;
         select       <= 3'd0;
         grant_valid  <= 1'b0;
         grant_onehot <= 8'd0;
         timeout      <= 1'b0;
         count        <= 8'd0;
      end else begin
         timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (found) begin
                  select       <= pick;
                  grant_onehot <= 8'b1 << pick;
                  grant_valid  <= 1'b1;
                  count        <= 8'd0;
                  state        <= GRANT;
               end
            end
            GRANT: begin
               if (rel_ack || rel_drop || rel_tmo) begin
                  state        <= IDLE;
                  grant_valid  <= 1'b0;
                  grant_onehot <= 8'd0;
                  ptr          <= select + 3'd1;
                  count        <= 8'd0;
                  // Timeout flagged only when it is the sole release cause.
                  timeout      <= rel_tmo && !rel_ack && !rel_drop;
               end else begin
                  count <= count + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign fsm_state = state;

endmodule

// File: tb/tb_rr_select_arbiter.sv
// Bench for rr_select_arbiter: directed vector table, hand sequences and
// randomized traffic against a behavioural model, on TIMEOUT=4 and TIMEOUT=1 instances.
module tb_rr_select_arbiter;

   logic       clock = 1'b0;
   logic       reset;
   logic [7:0] req;
   logic       ack;

   logic [2:0] sel_a, sel_b;
   logic       gv_a, gv_b, to_a, to_b, st_a, st_b;
   logic [7:0] oh_a, oh_b;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clock = ~clock;

   rr_select_arbiter #(.TIMEOUT(4)) u_dut_a (
      .clock(clock), .reset(reset), .req(req), .ack(ack),
      .select(sel_a), .grant_valid(gv_a), .grant_onehot(oh_a),
      .timeout(to_a), .fsm_state(st_a));

   rr_select_arbiter #(.TIMEOUT(1)) u_dut_b (
      .clock(clock), .reset(reset), .req(req), .ack(ack),
      .select(sel_b), .grant_valid(gv_b), .grant_onehot(oh_b),
      .timeout(to_b), .fsm_state(st_b));

   // Behavioural model: grant state, channel, pointer, cycles held so far.
   typedef struct {
      bit gnt;
      int ch;
      int ptr;
      int held;
      bit tmo;
   } model_t;

   model_t ma, mb;

   function automatic model_t model_next(model_t m, int t, logic r, logic [7:0] rq, logic a);
      model_t n = m;
      bit hit = 0;
      n.tmo = 0;
      if (r) begin
         n.gnt = 0; n.ch = 0; n.ptr = 0; n.held = 0;
      end else if (!m.gnt) begin
         if (rq != 8'd0) begin
            for (int k = 0; k < 8; k++) begin
               if (!hit && rq[(m.ptr + k) % 8]) begin
                  n.ch = (m.ptr + k) % 8;
                  hit = 1;
               end
            end
            n.gnt  = 1;
            n.held = 1;
         end
      end else if (a || !rq[m.ch] || m.held == t) begin
         n.gnt = 0;
         n.ptr = (m.ch + 1) % 8;
         n.tmo = !a && rq[m.ch];
      end else begin
         n.held = m.held + 1;
      end
      return n;
   endfunction

   function automatic logic [13:0] model_out(model_t m);
      logic [7:0] oh;
      oh = m.gnt ? (8'd1 << m.ch) : 8'd0;
      return {m.gnt, m.gnt, 3'(m.ch), oh, m.tmo};
   endfunction

   task automatic check(input string name, input logic [13:0] got, input logic [13:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (state,gv,sel,onehot,timeout)", name, got, exp);
      end
   endtask

   // Apply one cycle of inputs, advance the models at the edge, then check both instances.
   task automatic step(input logic r, input logic [7:0] rq, input logic a, input string tag);
      reset = r; req = rq; ack = a;
      @(posedge clock);
      ma = model_next(ma, 4, r, rq, a);
      mb = model_next(mb, 1, r, rq, a);
      #1;
      check({tag, "_model_t4"}, {st_a, gv_a, sel_a, oh_a, to_a}, model_out(ma));
      check({tag, "_model_t1"}, {st_b, gv_b, sel_b, oh_b, to_b}, model_out(mb));
   endtask

   typedef struct {
      logic       rst;
      logic [7:0] rq;
      logic       a;
      logic       gv;
      logic [2:0] sel;
      logic [7:0] oh;
      logic       to;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic rst, logic [7:0] rq, logic a,
                               logic gv, logic [2:0] sel, logic [7:0] oh, logic to);
      vec_t v;
      v.rst = rst; v.rq = rq; v.a = a; v.gv = gv; v.sel = sel; v.oh = oh; v.to = to;
      return v;
   endfunction

   initial begin
      reset = 1'b1; req = 8'd0; ack = 1'b0;
      ma = '{0, 0, 0, 0, 0};
      mb = '{0, 0, 0, 0, 0};

      // Expectations for the TIMEOUT=4 instance.
      vecs.push_back(mk(1, 8'h00, 0, 0, 3'd0, 8'h00, 0)); // reset
      vecs.push_back(mk(0, 8'h81, 0, 1, 3'd0, 8'h01, 0)); // alternate 0/7
      vecs.push_back(mk(0, 8'h81, 1, 0, 3'd0, 8'h00, 0));
      vecs.push_back(mk(0, 8'h81, 0, 1, 3'd7, 8'h80, 0));
      vecs.push_back(mk(0, 8'h81, 1, 0, 3'd7, 8'h00, 0));
      vecs.push_back(mk(0, 8'h81, 0, 1, 3'd0, 8'h01, 0));
      vecs.push_back(mk(0, 8'h81, 1, 0, 3'd0, 8'h00, 0));
      vecs.push_back(mk(0, 8'h81, 0, 1, 3'd7, 8'h80, 0));
      vecs.push_back(mk(0, 8'h81, 1, 0, 3'd7, 8'h00, 0));
      vecs.push_back(mk(0, 8'h04, 0, 1, 3'd2, 8'h04, 0)); // timeout run
      vecs.push_back(mk(0, 8'h04, 0, 1, 3'd2, 8'h04, 0));
      vecs.push_back(mk(0, 8'h04, 0, 1, 3'd2, 8'h04, 0));
      vecs.push_back(mk(0, 8'h04, 0, 1, 3'd2, 8'h04, 0));
      vecs.push_back(mk(0, 8'h04, 0, 0, 3'd2, 8'h00, 1));
      vecs.push_back(mk(0, 8'h04, 0, 1, 3'd2, 8'h04, 0)); // re-grant, pulse gone
      vecs.push_back(mk(0, 8'h04, 0, 1, 3'd2, 8'h04, 0));
      vecs.push_back(mk(0, 8'h04, 0, 1, 3'd2, 8'h04, 0));
      vecs.push_back(mk(0, 8'h04, 0, 1, 3'd2, 8'h04, 0));
      vecs.push_back(mk(0, 8'h04, 1, 0, 3'd2, 8'h00, 0)); // ack beats timeout
      vecs.push_back(mk(0, 8'h20, 0, 1, 3'd5, 8'h20, 0));
      vecs.push_back(mk(0, 8'h00, 0, 0, 3'd5, 8'h00, 0)); // req drop, select held
      vecs.push_back(mk(0, 8'h00, 0, 0, 3'd5, 8'h00, 0)); // idle holds
      vecs.push_back(mk(0, 8'h60, 0, 1, 3'd6, 8'h40, 0)); // ptr moved to 6
      vecs.push_back(mk(0, 8'h60, 0, 1, 3'd6, 8'h40, 0));
      vecs.push_back(mk(1, 8'h60, 0, 0, 3'd0, 8'h00, 0)); // reset mid-grant
      vecs.push_back(mk(0, 8'h60, 0, 1, 3'd5, 8'h20, 0)); // search from 0
      vecs.push_back(mk(0, 8'hFF, 1, 0, 3'd5, 8'h00, 0));
      vecs.push_back(mk(0, 8'hFF, 0, 1, 3'd6, 8'h40, 0));
      vecs.push_back(mk(0, 8'h46, 0, 1, 3'd6, 8'h40, 0)); // other bits change
      vecs.push_back(mk(0, 8'h40, 1, 0, 3'd6, 8'h00, 0));

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].rst, vecs[i].rq, vecs[i].a, $sformatf("vec%0d", i));
         check($sformatf("vec%0d_table", i), {gv_a, sel_a, oh_a, to_a},
               {vecs[i].gv, vecs[i].sel, vecs[i].oh, vecs[i].to});
      end

      // Full request set with ack: channels visited 0..7 then wrap to 0.
      step(1, 8'h00, 0, "ff_rst");
      for (int k = 0; k < 9; k++) begin
         step(0, 8'hFF, 0, "ff_grant");
         check($sformatf("ff_grant%0d", k), {gv_a, sel_a, oh_a}, {1'b1, 3'(k % 8), 8'd1 << (k % 8)});
         step(0, 8'hFF, 1, "ff_rel");
         check($sformatf("ff_rel%0d", k), {gv_a, oh_a, to_a}, {1'b0, 8'h00, 1'b0});
      end

      // TIMEOUT=1: grant held exactly one cycle, then timeout pulse.
      step(1, 8'h00, 0, "t1_rst");
      step(0, 8'h08, 0, "t1_grant");
      check("t1_grant", {gv_b, sel_b, to_b}, {1'b1, 3'd3, 1'b0});
      step(0, 8'h08, 0, "t1_rel");
      check("t1_rel", {gv_b, sel_b, to_b}, {1'b0, 3'd3, 1'b1});

      // Randomized traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         logic r;
         logic [7:0] rq;
         logic a;
         r  = ($urandom_range(0, 99) == 0);
         rq = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
         a  = ($urandom_range(0, 3) == 0);
         step(r, rq, a, "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
